// File: rtl/l2_responder_pkg.sv
// Shared bus package: word and responder-status types used by the bus controller
// and the L2 responder, plus the word-address legality check.
package l2_responder_pkg;

  typedef logic [31:0] bus_word_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // A legal address is word aligned and lies inside a store of 'depth' words.
  // The compare is done in 33 bits so depth*4 == 2**32 cannot wrap.
  function automatic logic word_addr_ok(input bus_word_t addr, input int unsigned depth);
    logic [32:0] limit;
    limit = 33'(depth) * 33'(WORD_BYTES);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/l2_sram.sv
// Single-port synchronous DEPTH x 32 backing store for the L2 responder.
// Read data is registered and only updates on a read access.
module l2_sram
  import l2_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  bus_word_t                wdata_i,
  output bus_word_t                rdata_o
);

  bus_word_t mem_q [DEPTH];
  bus_word_t rdata_q;

  // NOTE: the array has no reset so it maps onto a RAM macro; only the read
  // register is reset, which gives the responder its defined load value.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_responder.sv
// L2 word responder: accepts one read/write request at a time, spends LATENCY
// BUSY cycles, then performs the array access and signals ACCESS for one cycle.
module l2_responder
  import l2_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       l2REN,
  input  logic       l2WEN,
  input  logic [31:0] l2addr,
  input  bus_word_t  l2store,
  output bus_word_t  l2load,
  output l2_state_t  l2state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } fsm_t;

  fsm_t            state_q;
  logic            is_write_q;
  logic [AW-1:0]   idx_q;
  bus_word_t       wdata_q;
  logic [CW-1:0]   cnt_q;

  logic            req_any;
  logic            req_ok;
  logic            commit;

  assign req_any = l2REN | l2WEN;
  assign req_ok  = (l2REN ^ l2WEN) && word_addr_ok(l2addr, DEPTH);

  // The array is touched only on the BUSY->ACCESS edge of a request that is
  // still held; an abort in the final BUSY cycle suppresses it.
  assign commit = (state_q == BUSY) && req_any && (cnt_q == CW'(1));

  // NOTE: all state lives in one clocked block using non-blocking assignments,
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FREE;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        FREE: begin
          if (req_any) begin
            if (req_ok) begin
              is_write_q <= l2WEN;
              idx_q      <= l2addr[2 +: AW];
              wdata_q    <= l2store;
              cnt_q      <= CW'(LATENCY);
              state_q    <= BUSY;
            end else begin
              state_q    <= ERROR;
            end
          end
        end
        BUSY: begin
          if (!req_any) begin
            state_q <= FREE;
          end else if (cnt_q == CW'(1)) begin
            state_q <= ACCESS;
          end else begin
            cnt_q   <= cnt_q - CW'(1);
          end
        end
        ACCESS:  state_q <= FREE;
        ERROR:   state_q <= FREE;
        default: state_q <= FREE;
      endcase
    end
  end

  always_comb begin
    l2state = L2_FREE;
    case (state_q)
      FREE:    l2state = L2_FREE;
      BUSY:    l2state = L2_BUSY;
      ACCESS:  l2state = L2_ACCESS;
      ERROR:   l2state = L2_ERROR;
      default: l2state = L2_FREE;
    endcase
  end

  l2_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (CLK),
    .rst_n   (nRST),
    .en_i    (commit),
    .we_i    (is_write_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (l2load)
  );

endmodule

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning backing-store size in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2, meaning number of BUSY cycles per word access (>=1).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port l2REN  input  1  word read request from the bus controller, held until L2_ACCESS is seen.
REQ-006 SHALL have port l2WEN  input  1  word write request from the bus controller, held until L2_ACCESS is seen.
REQ-007 SHALL have port l2addr  input  32  byte address of the word; must be word aligned.
REQ-008 SHALL have port l2store  input  32  write data.
REQ-009 SHALL have port l2load  output  32  read data, registered, valid in the L2_ACCESS cycle of a read.
REQ-010 SHALL have port l2state  output  l2_state_t  responder status: L2_FREE, L2_BUSY, L2_ACCESS or L2_ERROR.

Function
REQ-011 SHALL implement FSM states FREE, BUSY, ACCESS, ERROR; l2state SHALL be a pure decode of the current state.
REQ-012 In FREE with exactly one of l2REN/l2WEN high and a valid address, SHALL latch operation, word index l2addr[2+:log2(DEPTH)] and l2store, load counter with LATENCY, and go to BUSY.
REQ-013 Address valid means l2addr[1:0]==0 and l2addr < DEPTH*4; otherwise, or if l2REN and l2WEN are both high in FREE, SHALL go to ERROR.
REQ-014 ERROR SHALL last exactly one cycle, then go to FREE; no array access SHALL occur for an erroring request.
REQ-015 In BUSY SHALL decrement the counter each cycle and go to ACCESS when it reaches 1, giving exactly LATENCY BUSY cycles.
REQ-016 On the BUSY->ACCESS edge, a latched write SHALL commit l2store to the array and a latched read SHALL register the array word into l2load.
REQ-017 ACCESS SHALL last exactly one cycle, then go to FREE unconditionally; a still-held request is treated as a new request in FREE.
REQ-018 Acceptance-to-ACCESS latency SHALL be LATENCY+1 cycles; per-word period for back-to-back requests SHALL be LATENCY+2 cycles.
REQ-019 If l2REN and l2WEN are both low in any BUSY cycle (bus abort), SHALL go to FREE next cycle; no write commit and no l2load update SHALL occur.
REQ-020 A change of l2addr, l2store or request type during BUSY SHALL be ignored; the latched operation completes.
REQ-021 l2load SHALL hold its last value outside read ACCESS cycles.
REQ-022 A read of a word written earlier SHALL return the written data; a read never written returns unspecified data.

Reset
REQ-023 On nRST low, the FSM SHALL go to FREE, the counter and latches SHALL clear, and l2load SHALL be 0, all asynchronously.
REQ-024 Array contents SHALL NOT be reset; reset during BUSY SHALL abort the access with no commit.

Structure
REQ-025 l2_state_t and bus_word_t SHALL come from the shared bus package used by the bus controller; no local redefinition.
REQ-026 The storage array SHALL be a sub-module l2_sram (one synchronous read/write port, DEPTH x 32); FSM, counter and address checks stay in l2_responder.

Verification (DEPTH=1024, LATENCY=2)
REQ-027 Write 0xDEADBEEF to 0x10, WEN held from t0 -> l2state FREE t0, BUSY t1-t2, ACCESS t3, FREE t4; later read of 0x10 returns 0xDEADBEEF in its ACCESS cycle.
REQ-028 Two-word read 0x20 then 0x24, REN held, address stepped the cycle after ACCESS -> ACCESS at t3 and t7, l2load equals preloaded words in each.
REQ-029 Write to 0x40 (old 0x11111111) with WEN dropped at t1 -> FREE at t2, no ACCESS, re-read returns 0x11111111.
REQ-030 REN and WEN both high at 0x0 -> ERROR one cycle, then FREE, array unchanged.
REQ-031 Read of 0x1000 (DEPTH*4) and read of 0x13 -> ERROR each, l2load unchanged.
REQ-032 nRST pulsed low during BUSY of a write of 0xCAFEF00D to 0x8 -> state FREE, l2load 0 immediately, word 0x8 unchanged.
